// File: rtl/rx_beam_combiner_if.sv
// ----------------------------------------------------------------------------
// rx_beam_combiner_if
//   Bundles the element inputs, steering select and beam outputs of the
//   receive beam combiner.
//   Signals:
//     elem_in    [N_CH-1:0]  raw receiver element bits (asynchronous to clk)
//     select     [3:0]       steering angle index, 0..15 = -30..+30 deg
//     beam_sum   [4:0]       count of aligned element bits
//     beam_bit               thresholded beam decision
//     beam_valid             one-cycle strobe when beam_sum/beam_bit update
//   Modports:
//     master  drives elem_in/select, observes the beam outputs
//     slave   the combiner itself
// ----------------------------------------------------------------------------
interface rx_beam_combiner_if #(
    parameter int N_CH = 20
);
    logic [N_CH-1:0] elem_in;
    logic [3:0]      select;
    logic [4:0]      beam_sum;
    logic            beam_bit;
    logic            beam_valid;

    modport master (
        output elem_in, select,
        input  beam_sum, beam_bit, beam_valid
    );

    modport slave (
        input  elem_in, select,
        output beam_sum, beam_bit, beam_valid
    );
endinterface

// File: rtl/rx_beam_combiner.sv
// ----------------------------------------------------------------------------
// rx_beam_combiner
//   Samples N_CH receiver element bits once per DECIM-cycle frame into a
//   2^ADDR_W-deep history RAM, then reads each element back with the delay
//   for the latched steering angle and counts the aligned bits into a beam
//   value.
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   rx_beam_combiner_if.slave: elem_in, select in; beam_sum,
//           beam_bit, beam_valid out
//   Frame timeline (phase = cycle within frame):
//     0          store sample, latch select, bump fill, clear accumulator
//     1..N_CH    one history read per element
//     2..N_CH+1  accumulate read bits (1-cycle RAM latency)
//     N_CH+2     publish beam_sum/beam_bit, strobe beam_valid
// ----------------------------------------------------------------------------
module rx_beam_combiner #(
    parameter int N_CH   = 20,
    parameter int DECIM  = 32,
    parameter int ADDR_W = 8,
    parameter int THRESH = 11
) (
    input  logic                clk,
    input  logic                rst,
    rx_beam_combiner_if.slave   bus
);
    localparam int PH_W  = $clog2(DECIM);
    localparam int CH_W  = $clog2(N_CH);
    localparam int SUM_W = 5;

    localparam logic [PH_W-1:0]   PH_LAST      = PH_W'(DECIM - 1);
    localparam logic [PH_W-1:0]   PH_RD_FIRST  = PH_W'(1);
    localparam logic [PH_W-1:0]   PH_RD_LAST   = PH_W'(N_CH);
    localparam logic [PH_W-1:0]   PH_ACC_FIRST = PH_W'(2);
    localparam logic [PH_W-1:0]   PH_ACC_LAST  = PH_W'(N_CH + 1);
    localparam logic [PH_W-1:0]   PH_OUT       = PH_W'(N_CH + 2);
    localparam logic [ADDR_W-1:0] FILL_MAX     = '1;

    // Delay increment per scanned element, in samples.
    function automatic logic [ADDR_W-1:0] step_rom(input logic [3:0] sel);
        logic [ADDR_W-1:0] s;
        case (sel)
            4'd0, 4'd15: s = ADDR_W'(13);
            4'd1, 4'd14: s = ADDR_W'(12);
            4'd2, 4'd13: s = ADDR_W'(10);
            4'd3, 4'd12: s = ADDR_W'(8);
            4'd4, 4'd11: s = ADDR_W'(6);
            4'd5, 4'd10: s = ADDR_W'(4);
            4'd6, 4'd9:  s = ADDR_W'(3);
            default:     s = ADDR_W'(1);
        endcase
        return s;
    endfunction

    // Positive angles scan from the top element down so the first scanned
    // element is always the one with zero delay.
    function automatic logic [CH_W-1:0] scan_ch(input logic [3:0] sel,
                                                input logic [CH_W-1:0] idx);
        return sel[3] ? (CH_W'(N_CH - 1) - idx) : idx;
    endfunction

    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
        return (v == FILL_MAX) ? v : v + ADDR_W'(1);
    endfunction

    logic [N_CH-1:0]   elem_meta_p0;
    logic [N_CH-1:0]   elem_sync_p1;
    logic [N_CH-1:0]   mem [2**ADDR_W];
    logic [N_CH-1:0]   rd_word_p1;
    logic [CH_W-1:0]   rd_ch_p1;
    logic              vld_p1;

    logic [PH_W-1:0]   phase;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] fill;
    logic [ADDR_W-1:0] addr_base;
    logic [ADDR_W-1:0] delay;
    logic [3:0]        sel_l;
    logic [SUM_W-1:0]  acc;

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_bit;

    assign step    = step_rom(sel_l);
    assign rd_addr = addr_base - delay;
    assign rd_bit  = rd_word_p1[rd_ch_p1] & vld_p1;

    // ---- stage p0/p1: two-flop synchroniser on the asynchronous element bits
    always_ff @(posedge clk) begin
        elem_meta_p0 <= bus.elem_in;
        elem_sync_p1 <= elem_meta_p0;
    end

    // ---- stage p1: history RAM, write at phase 0, registered read
    always_ff @(posedge clk) begin
        if (phase == '0) begin
            mem[wptr] <= elem_sync_p1;
        end
        rd_word_p1 <= mem[rd_addr];
    end

    // Frame sequencer, read issue, accumulation and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase         <= '0;
            wptr          <= '0;
            fill          <= '0;
            addr_base     <= '0;
            delay         <= '0;
            sel_l         <= '0;
            acc           <= '0;
            rd_ch_p1      <= '0;
            vld_p1        <= 1'b0;
            bus.beam_sum   <= '0;
            bus.beam_bit   <= 1'b0;
            bus.beam_valid <= 1'b0;
        end else begin
            phase          <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
            vld_p1         <= 1'b0;
            bus.beam_valid <= 1'b0;

            if (phase == '0) begin
                sel_l     <= bus.select;
                fill      <= sat_inc(fill);
                acc       <= '0;
                delay     <= '0;
                addr_base <= wptr;
                wptr      <= wptr + ADDR_W'(1);
            end

            // ---- stage p1: issue read for scan index phase-1
            if ((phase >= PH_RD_FIRST) && (phase <= PH_RD_LAST)) begin
                vld_p1   <= (delay < fill);
                rd_ch_p1 <= scan_ch(sel_l, CH_W'(phase - PH_W'(1)));
                delay    <= delay + step;
            end

            // ---- stage p2: accumulate aligned bit
            if ((phase >= PH_ACC_FIRST) && (phase <= PH_ACC_LAST)) begin
                acc <= acc + SUM_W'(rd_bit);
            end

            if (phase == PH_OUT) begin
                bus.beam_sum   <= acc;
                bus.beam_bit   <= (acc >= SUM_W'(THRESH));
                bus.beam_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rx_beam_combiner.sv
module tb_rx_beam_combiner;
    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    rx_beam_combiner_if bus ();

    rx_beam_combiner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int step_tab [16] = '{13, 12, 10, 8, 6, 4, 3, 1, 1, 3, 4, 6, 8, 10, 12, 13};

    logic [19:0] hist [0:640];
    logic [3:0]  selh [0:640];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Waits for the next beam_valid (sampled on the falling edge); n is the
    // number of falling edges waited.
    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.beam_valid && n < 64);
        if (!bus.beam_valid) check("strobe_seen", int'(bus.beam_valid), 1);
    endtask

    task automatic do_reset(input logic [19:0] e, input logic [3:0] s);
        @(negedge clk);
        rst = 1'b1;
        bus.elem_in = e;
        bus.select  = s;
        repeat (4) @(negedge clk);
        rst = 1'b0;
    endtask

    // Element k high only in frame T-(19-k)*13.
    function automatic logic [19:0] pulse_vec(input int f, input int t);
        logic [19:0] v;
        v = '0;
        for (int k = 0; k < 20; k++)
            if (f == t - (19 - k) * 13) v[k] = 1'b1;
        return v;
    endfunction

    function automatic int model_sum(input int f);
        int s, sum, d, ch, fl;
        s   = step_tab[selh[f]];
        fl  = (f < 255) ? f : 255;
        sum = 0;
        for (int i = 0; i < 20; i++) begin
            ch = (selh[f] >= 4'd8) ? 19 - i : i;
            d  = i * s;
            if (d < fl) sum += int'(hist[f - d][ch]);
        end
        return sum;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, e, vc;
        logic [31:0] r;

        // Reset state, strobe timing, all-ones ramp with select 8.
        rst = 1'b1;
        bus.elem_in = '1;
        bus.select  = 4'd8;
        repeat (4) @(negedge clk);
        check("rst_sum",   int'(bus.beam_sum),   0);
        check("rst_bit",   int'(bus.beam_bit),   0);
        check("rst_valid", int'(bus.beam_valid), 0);
        rst = 1'b0;

        wait_strobe(w);
        check("first_strobe_cycle", w - 1, 22);
        check("t2_sum", int'(bus.beam_sum), 1);
        check("t2_bit", int'(bus.beam_bit), 0);
        for (int n = 2; n <= 25; n++) begin
            wait_strobe(w);
            if (n == 2) check("strobe_period", w, 32);
            check("t2_sum", int'(bus.beam_sum), (n < 20) ? n : 20);
            check("t2_bit", int'(bus.beam_bit), (n >= 11) ? 1 : 0);
            if (n == 5) begin
                repeat (10) @(negedge clk);
                check("hold_sum",   int'(bus.beam_sum),   5);
                check("hold_valid", int'(bus.beam_valid), 0);
            end
        end

        // Single-frame pulses aligned for select 15 (step 13, descending scan).
        do_reset(pulse_vec(1, 260), 4'd15);
        for (int f = 1; f <= 300; f++) begin
            wait_strobe(w);
            check("t3_sum", int'(bus.beam_sum), (f == 260) ? 20 : 0);
            check("t3_bit", int'(bus.beam_bit), (f == 260) ? 1 : 0);
            bus.elem_in = pulse_vec(f + 1, 260);
        end

        // Same pulses with select 0: each element lines up in its own frame.
        do_reset(pulse_vec(1, 260), 4'd0);
        for (int f = 1; f <= 520; f++) begin
            wait_strobe(w);
            e = (f >= 13 && f <= 507 && ((f - 13) % 26) == 0) ? 1 : 0;
            check("t4_sum", int'(bus.beam_sum), e);
            check("t4_bit", int'(bus.beam_bit), 0);
            bus.elem_in = pulse_vec(f + 1, 260);
        end

        // Random data, mid-frame select changes, past the write-pointer wrap.
        r = $urandom;
        hist[1] = r[19:0];
        selh[1] = 4'd15;
        do_reset(r[19:0], 4'd15);
        for (int f = 1; f <= 600; f++) begin
            wait_strobe(w);
            e = model_sum(f);
            check("t5_sum", int'(bus.beam_sum), e);
            check("t5_bit", int'(bus.beam_bit), (e >= 11) ? 1 : 0);
            r = $urandom;
            bus.elem_in = r[19:0];
            if (f % 80 == 40) bus.select = 4'($urandom_range(0, 7));
            hist[f + 1] = r[19:0];
            selh[f + 1] = bus.select;
            if (f % 80 == 20 || f % 80 == 60) begin
                repeat (15) @(posedge clk);
                #1 bus.select = (f % 80 == 20) ? 4'd8 : 4'd15;
            end
        end

        // Reset asserted mid-frame.
        do_reset('1, 4'd8);
        for (int n = 1; n <= 3; n++) begin
            wait_strobe(w);
            check("t6_pre_sum", int'(bus.beam_sum), n);
        end
        repeat (19) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_sum",   int'(bus.beam_sum),   0);
        check("t6_rst_valid", int'(bus.beam_valid), 0);
        vc = 0;
        repeat (5) begin
            @(negedge clk);
            vc += int'(bus.beam_valid);
        end
        check("t6_no_strobe", vc, 0);
        rst = 1'b0;
        wait_strobe(w);
        check("t6_restart_cycle", w - 1, 22);
        check("t6_sum", int'(bus.beam_sum), 1);
        for (int n = 2; n <= 3; n++) begin
            wait_strobe(w);
            check("t6_sum", int'(bus.beam_sum), n);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
